mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM cycles spent on each 16-bit half access, legal range 1..15.
REQ-002 Parameter ADDR_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 Parameter SRAM_AW, default 18: SRAM half-word address width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 rd_en  input  1  load request from the EXE/MEM pipeline register.
REQ-007 wr_en  input  1  store request from the EXE/MEM pipeline register.
REQ-008 address  input  32  byte address (ALU result).
REQ-009 wr_data  input  32  store value.
REQ-010 rd_data  output  32  registered load result.
REQ-011 ready  output  1  low means the pipeline freezes; high means the access is complete or no request is pending.
REQ-012 sram_addr  output  SRAM_AW  half-word address.
REQ-013 sram_dq_out  output  16  write data.
REQ-014 sram_dq_oe  output  1  drive enable for the tri-state pad; the pad itself sits outside the block.
REQ-015 sram_dq_in  input  16  read data.
REQ-016 sram_we_n  output  1  active-low write strobe.

Function
REQ-017 word = (address - ADDR_BASE) >> 2, computed as unsigned 32-bit and wrapping mod 2^32; sram_addr = {word[SRAM_AW-2:0], half}, where half=0 addresses bits 15:0 and half=1 addresses bits 31:16.
REQ-018 FSM states: IDLE, LOW, HIGH, DONE.
REQ-019 IDLE: if rd_en or wr_en, go to LOW; otherwise stay in IDLE.
REQ-020 LOW: hold for WAIT_CYCLES cycles with half=0, then go to HIGH.
REQ-021 HIGH: hold for WAIT_CYCLES cycles with half=1, then go to DONE.
REQ-022 DONE: go to IDLE unconditionally after one cycle.
REQ-023 ready = ~(rd_en | wr_en) | (state == DONE), combinational.
REQ-024 Upstream holds address, wr_data, rd_en and wr_en stable while ready=0.
REQ-025 A request seen in IDLE gives ready=1 exactly 2*WAIT_CYCLES+1 cycles later (5 cycles at the default).
REQ-026 Writes: during LOW and HIGH, sram_dq_oe=1 and sram_dq_out carries the selected half; sram_we_n=0 on every cycle of those states except the last cycle of each state, where it is 1 so the data hold time is met.
REQ-027 Reads: sram_dq_oe=0 and sram_we_n=1; the low half is captured on the last LOW cycle and the high half on the last HIGH cycle; rd_data updates on entry to DONE.
REQ-028 rd_data holds its value until the next read completes; writes never change it.
REQ-029 If rd_en and wr_en are both high, the write is performed and the read is ignored.
REQ-030 A request that drops while the FSM is in LOW or HIGH is protocol misuse; the FSM still finishes the sequence.

Reset
REQ-031 rst=0 forces state=IDLE, the wait counter to 0, rd_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0, with any access in flight abandoned.
REQ-032 The first request after reset is released is serviced normally.

Configuration
REQ-033 Macro MEM_STAGE_RD_BUF_EN, when defined, adds a one-entry read buffer holding a valid bit, the word address and 32 data bits.
REQ-034 With the buffer enabled, a read in IDLE whose word matches a valid entry skips LOW and HIGH, goes directly to DONE and loads rd_data from the buffer, so ready rises one cycle after the request.
REQ-035 With the buffer enabled, every completed SRAM read fills the buffer.
REQ-036 With the buffer enabled, a completed write to the buffered word updates the buffer data.
REQ-037 With the buffer enabled, reset clears the valid bit.
REQ-038 Without the macro, no buffer storage exists and every read takes the full latency in REQ-025.

Structure
REQ-039 A shared package holds the FSM state enum, the ADDR_BASE default and the SRAM data width constant of 16.
REQ-040 The wait counter and the half select live in one sub-module, sram_half_seq, which emits a last-cycle pulse and a half index.

Verification
REQ-041 Write 0xDEADBEEF to address 1024 at WAIT_CYCLES=2 -> ready is low for cycles 0-4; 0xBEEF is driven to sram_addr 0 and 0xDEAD to sram_addr 1; ready=1 in cycle 5.
REQ-042 Read address 1024 with the SRAM model returning 0xBEEF then 0xDEAD -> rd_data=0xDEADBEEF in cycle 5 and held there through the following idle cycles.
REQ-043 rd_en=wr_en=1, address 1028, wr_data 0x12345678 -> SRAM words 2 and 3 are written and rd_data is unchanged.
REQ-044 rst is pulsed low during HIGH of a write -> sram_we_n=1, sram_dq_oe=0 and state=IDLE immediately; the SRAM is left with a partial word; the next read runs the full 5 cycles.
REQ-045 With MEM_STAGE_RD_BUF_EN defined: two back-to-back reads of address 1032 -> the first takes 5 cycles and the second 1 cycle with identical data; after a write of 0x0 to 1032, a read returns 0x0 in 1 cycle.
REQ-046 address 0 (below ADDR_BASE) -> word wraps to 0x3FFFFF00 and sram_addr = {word[16:0], half}.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default SRAM base address, SRAM data width and the word-index helper.
package mem_stage_ctrl_pkg;

  localparam int unsigned ADDR_BASE_DEFAULT = 1024;
  localparam int          SRAM_DW           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Word index of a byte address relative to the SRAM base; wraps mod 2^32
  // so addresses below the base alias high in the word space.
  function automatic logic [31:0] word_of(input logic [31:0] addr,
                                          input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_sram_half_seq.sv
// Wait-state sequencer for one 32-bit access split into two 16-bit halves.
// Counts WAIT_CYCLES per half while active, pulses o_last on the final cycle
// of each half and flips o_half after the low half completes.
module sram_half_seq #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,        // active-low, asynchronous
  input  logic i_active,
  output logic o_last,
  output logic o_half
);

  logic [3:0] r_cnt;
  logic       r_half;

  assign o_last = i_active && (r_cnt == 4'(WAIT_CYCLES - 1));
  assign o_half = r_half;

  // Wait counter and half select; both fall back to zero whenever idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (!i_active) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (o_last) begin
      r_cnt  <= '0;
      r_half <= ~r_half;
    end else begin
      r_cnt  <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns a 32-bit load/store from the pipeline into two
// 16-bit SRAM accesses and freezes the pipeline (ready=0) until done.
// Optional feature: define MEM_STAGE_RD_BUF_EN for a one-entry read buffer
// that lets a repeated read of the same word complete in one cycle.
import mem_stage_ctrl_pkg::*;

module mem_stage_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,          // active-low, asynchronous
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_is_wr;
  logic [15:0]  r_lo;
  logic [31:0]  r_rd_data;
  logic         w_req;
  logic         w_active;
  logic         w_last;
  logic         w_half;
  logic         w_hit;
  logic [31:0]  w_word;

  assign w_req    = rd_en | wr_en;
  assign w_word   = word_of(address, 32'(ADDR_BASE));
  assign w_active = (r_state == ST_LOW) || (r_state == ST_HIGH);
  assign ready    = ~w_req | (r_state == ST_DONE);
  assign rd_data  = r_rd_data;

  sram_half_seq #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .i_active(w_active),
    .o_last  (w_last),
    .o_half  (w_half)
  );

`ifdef MEM_STAGE_RD_BUF_EN
  logic        r_buf_vld;
  logic [31:0] r_buf_word;
  logic [31:0] r_buf_data;

  // A pure read of the buffered word can skip the SRAM entirely.
  assign w_hit = rd_en & ~wr_en & r_buf_vld & (r_buf_word == w_word);

  // Buffer fill on every completed SRAM read; refresh on a write to the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_word <= '0;
      r_buf_data <= '0;
    end else if (r_state == ST_HIGH && w_last) begin
      if (!r_is_wr) begin
        r_buf_vld  <= 1'b1;
        r_buf_word <= w_word;
        r_buf_data <= {sram_dq_in, r_lo};
      end else if (r_buf_vld && r_buf_word == w_word) begin
        r_buf_data <= wr_data;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next state and SRAM pin decode; pins are quiet outside LOW/HIGH so that
  // reset releases the bus immediately. we_n rises on the last cycle of each
  // half to give the SRAM data hold time while oe is still asserted.
  always_comb begin
    w_state_next = r_state;
    sram_addr    = '0;
    sram_dq_out  = '0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;
    case (r_state)
      ST_IDLE: if (w_req) w_state_next = w_hit ? ST_DONE : ST_LOW;
      ST_LOW:  if (w_last) w_state_next = ST_HIGH;
      ST_HIGH: if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_active) begin
      sram_addr = SRAM_AW'({w_word, w_half});
      if (r_is_wr) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = w_last;
        sram_dq_out = w_half ? wr_data[31:16] : wr_data[15:0];
      end
    end
  end

  // Access type latch and read-data assembly (low half, then full word on DONE entry).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_wr   <= 1'b0;
      r_lo      <= '0;
      r_rd_data <= '0;
    end else begin
      // A write wins when both requests are raised together.
      if (r_state == ST_IDLE && w_req)
        r_is_wr <= wr_en;
      if (r_state == ST_LOW && w_last && !r_is_wr)
        r_lo <= sram_dq_in;
      if (r_state == ST_HIGH && w_last && !r_is_wr)
        r_rd_data <= {sram_dq_in, r_lo};
`ifdef MEM_STAGE_RD_BUF_EN
      if (r_state == ST_IDLE && w_hit)
        r_rd_data <= r_buf_data;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl at WAIT_CYCLES=2. Stimulus pushes the
// expected outcome of each request; a monitor pops and compares when ready
// completes a pending request. Honours MEM_STAGE_RD_BUF_EN if defined.
module tb_mem_stage_ctrl;

  localparam int W = 2;
`ifdef MEM_STAGE_RD_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int FULL_LAT = 2 * W + 1;
  localparam int HIT_LAT  = BUF ? 1 : FULL_LAT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wr_data = '0;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n));

  // Asynchronous-read SRAM model, written on a clock edge while we_n is low.
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    bit          chk_seq;
    logic [17:0] a_lo;
    bit          is_wr;
    logic [15:0] d_lo;
    logic [15:0] d_hi;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_tx(input int lat, input logic [31:0] rd, input bit seq,
                           input logic [17:0] a_lo, input bit is_wr, input logic [31:0] d);
    exp_t e;
    e.lat = lat; e.rd = rd; e.chk_seq = seq; e.a_lo = a_lo; e.is_wr = is_wr;
    e.d_lo = d[15:0]; e.d_hi = d[31:16];
    sb.push_back(e);
  endtask

  task automatic run(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; wr_data = d;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 cycles (addr 0x%0h)", a);
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Monitor: time each request, record the SRAM pin trace, compare on ready.
  initial begin
    int          cyc;
    logic [17:0] s_lo, s_hi;
    logic [15:0] q_lo, q_hi;
    logic [3:0]  we_pat, oe_pat;
    exp_t        e;
    cyc = 0; s_lo = '0; s_hi = '0; q_lo = '0; q_hi = '0; we_pat = '0; oe_pat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0;
      end else if (rd_en || wr_en) begin
        if (cyc >= 1 && cyc <= 4) begin
          we_pat[cyc-1] = sram_we_n;
          oe_pat[cyc-1] = sram_dq_oe;
        end
        if (cyc == 1)     begin s_lo = sram_addr; q_lo = sram_dq_out; end
        if (cyc == 1 + W) begin s_hi = sram_addr; q_hi = sram_dq_out; end
        if (ready) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got completion expected none pending");
          end else begin
            e = sb.pop_front();
            check("latency", 64'(cyc), 64'(e.lat));
            check("rd_data", 64'(rd_data), 64'(e.rd));
            if (e.chk_seq) begin
              check("addr_lo", 64'(s_lo), 64'(e.a_lo));
              check("addr_hi", 64'(s_hi), 64'(e.a_lo + 18'd1));
              check("we_n_trace", 64'(we_pat), e.is_wr ? 64'hA : 64'hF);
              check("oe_trace",   64'(oe_pat), e.is_wr ? 64'hF : 64'h0);
              if (e.is_wr) begin
                check("dq_out_lo", 64'(q_lo), 64'(e.d_lo));
                check("dq_out_hi", 64'(q_hi), 64'(e.d_hi));
                check("mem_lo", 64'(mem[e.a_lo]), 64'(e.d_lo));
                check("mem_hi", 64'(mem[e.a_lo + 18'd1]), 64'(e.d_hi));
              end
            end
          end
          cyc = 0;
        end else begin
          cyc++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish before 300000");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    for (int i = 0; i < 262144; i++) mem[i] <= 16'h0000;
    @(posedge clk);
    mem[18'h3FE00] <= 16'h1111;
    mem[18'h3FE01] <= 16'h2222;
    mem[18'd4]     <= 16'hA5A5;
    mem[18'd5]     <= 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", 64'(rd_data), 64'h0);
    check("rst_we_n",    64'(sram_we_n), 64'h1);
    check("rst_oe",      64'(sram_dq_oe), 64'h0);
    check("rst_addr",    64'(sram_addr), 64'h0);
    check("rst_dq_out",  64'(sram_dq_out), 64'h0);
    check("rst_ready",   64'(ready), 64'h1);
    @(negedge clk); rst = 1'b1;

    // Write 0xDEADBEEF to 1024, then read it back.
    expect_tx(FULL_LAT, 32'h0, 1'b1, 18'd0, 1'b1, 32'hDEADBEEF);
    run(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    expect_tx(FULL_LAT, 32'hDEADBEEF, 1'b1, 18'd0, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd1024, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("rd_hold", 64'(rd_data), 64'hDEADBEEF);
    end

    // Simultaneous read and write: write wins, rd_data unchanged.
    expect_tx(FULL_LAT, 32'hDEADBEEF, 1'b1, 18'd2, 1'b1, 32'h12345678);
    run(1'b1, 1'b1, 32'd1028, 32'h12345678);
    @(negedge clk);
    check("rdwr_rd_keep", 64'(rd_data), 64'hDEADBEEF);

    // Reset in the first HIGH cycle of a write to 1040 (half-words 8/9).
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; wr_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2;
    check("abort_addr_hi", 64'(sram_addr), 64'd9);
    check("abort_we_n_pre", 64'(sram_we_n), 64'h0);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("abort_we_n", 64'(sram_we_n), 64'h1);
    check("abort_oe",   64'(sram_dq_oe), 64'h0);
    check("abort_addr", 64'(sram_addr), 64'h0);
    check("abort_rd",   64'(rd_data), 64'h0);
    @(negedge clk); rst = 1'b1;
    check("abort_mem_lo", 64'(mem[8]), 64'hF00D);
    check("abort_mem_hi", 64'(mem[9]), 64'h0);

    // First read after reset takes the full latency.
    expect_tx(FULL_LAT, 32'h12345678, 1'b1, 18'd2, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd1028, 32'h0);

    // Address below the base wraps: word 0x3FFFFF00 -> half-words 0x3FE00/01.
    expect_tx(FULL_LAT, 32'h22221111, 1'b1, 18'h3FE00, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd0, 32'h0);

    // Repeated reads of 1032, a write of zero, and a read back.
    expect_tx(FULL_LAT, 32'h5A5AA5A5, 1'b1, 18'd4, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd1032, 32'h0);
    expect_tx(HIT_LAT, 32'h5A5AA5A5, !BUF, 18'd4, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd1032, 32'h0);
    expect_tx(FULL_LAT, 32'h5A5AA5A5, 1'b1, 18'd4, 1'b1, 32'h0);
    run(1'b0, 1'b1, 32'd1032, 32'h0);
    expect_tx(HIT_LAT, 32'h0, !BUF, 18'd4, 1'b0, 32'h0);
    run(1'b1, 1'b0, 32'd1032, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
